// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: stall/redirect/fetch control bus between the pc sequencer and its fetch stage
interface pc_sequencer_if #(
    parameter int XLEN      = 32,
    parameter int NUM_STALL = 7,
    parameter int CNT_W     = 16
);
    logic [NUM_STALL-1:0] stallReq;
    logic                 redirectValid;
    logic [XLEN-1:0]      redirectTarget;
    logic                 fetchReady;
    logic [XLEN-1:0]      pc;
    logic                 fetchValid;
    logic                 available;
    logic                 decodeValid;
    logic                 redirectTaken;
    logic [CNT_W-1:0]     fetchCount;

    modport master (
        output stallReq, redirectValid, redirectTarget, fetchReady,
        input  pc, fetchValid, available, decodeValid, redirectTaken, fetchCount
    );

    modport slave (
        input  stallReq, redirectValid, redirectTarget, fetchReady,
        output pc, fetchValid, available, decodeValid, redirectTaken, fetchCount
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with stall hold, redirect bubble and fetch counting
module pc_sequencer #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
    parameter int                INC          = 4,
    parameter int                NUM_STALL    = 7,
    parameter int                CNT_W        = 16
) (
    input  logic           clock,
    input  logic           resetN,
    pc_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {BOOT, RUN, BUBBLE} state_t;

    localparam logic [XLEN-1:0] STEP       = XLEN'(INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INC - 1));

    state_t           r_state;
    logic [XLEN-1:0]  r_pc;
    logic [CNT_W-1:0] r_fetch_count;
    logic             r_decode_valid;
    logic             r_redirect_taken;
    logic             w_available;
    logic             w_fetch_valid;
    logic             w_fire;

    assign w_available   = ~|bus.stallReq;
    assign w_fetch_valid = (r_state == RUN) & w_available;
    assign w_fire        = w_fetch_valid & bus.fetchReady;

    // Redirect outranks increment; a fire coinciding with a redirect is counted but squashed from decode
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state          <= BOOT;
            r_pc             <= RESET_VECTOR;
            r_fetch_count    <= '0;
            r_decode_valid   <= 1'b0;
            r_redirect_taken <= 1'b0;
        end else begin
            r_redirect_taken <= bus.redirectValid;
            r_decode_valid   <= w_fire & ~bus.redirectValid;
            if (w_fire)
                r_fetch_count <= r_fetch_count + CNT_W'(1);
            if (bus.redirectValid) begin
                r_pc    <= bus.redirectTarget & ALIGN_MASK;
                r_state <= BUBBLE;
            end else begin
                if (w_fire)
                    r_pc <= r_pc + STEP;
                r_state <= RUN;
            end
        end
    end

    assign bus.pc            = r_pc;
    assign bus.fetchValid    = w_fetch_valid;
    assign bus.available     = w_available;
    assign bus.decodeValid   = r_decode_valid;
    assign bus.redirectTaken = r_redirect_taken;
    assign bus.fetchCount    = r_fetch_count;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed stimulus with a cycle-level reference model and literal spot checks
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.XLEN(32), .NUM_STALL(7), .CNT_W(16)) bus ();
    pc_sequencer_if #(.XLEN(8),  .NUM_STALL(7), .CNT_W(2))  sbus ();

    pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .INC(4), .NUM_STALL(7), .CNT_W(16)) dut (
        .clock(clk), .resetN(resetN), .bus(bus)
    );

    pc_sequencer #(.XLEN(8), .RESET_VECTOR(8'h0), .INC(4), .NUM_STALL(7), .CNT_W(2)) dut_small (
        .clock(clk), .resetN(resetN), .bus(sbus)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: after any edge fetching is enabled unless that edge took a redirect
    // (BOOT and BUBBLE both amount to one dead cycle).
    logic [31:0] m_pc;
    logic [15:0] m_cnt;
    logic        m_live, m_dec, m_rt, m_fire;

    assign m_fire = m_live && (bus.stallReq == 0) && bus.fetchReady;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_pc   <= 32'h0;
            m_cnt  <= 16'h0;
            m_live <= 1'b0;
            m_dec  <= 1'b0;
            m_rt   <= 1'b0;
        end else begin
            m_live <= !bus.redirectValid;
            m_rt   <= bus.redirectValid;
            m_dec  <= m_fire && !bus.redirectValid;
            m_cnt  <= m_cnt + (m_fire ? 16'd1 : 16'd0);
            m_pc   <= bus.redirectValid ? {bus.redirectTarget[31:2], 2'b00}
                                        : m_pc + (m_fire ? 32'd4 : 32'd0);
        end
    end

    always @(negedge clk) begin
        chk("pc", bus.pc, m_pc);
        chk("fetchValid", bus.fetchValid, m_live && (bus.stallReq == 0));
        chk("available", bus.available, bus.stallReq == 0);
        chk("decodeValid", bus.decodeValid, m_dec);
        chk("redirectTaken", bus.redirectTaken, m_rt);
        chk("fetchCount", bus.fetchCount, m_cnt);
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        bus.stallReq = '0;
        bus.redirectValid = 1'b0;
        bus.redirectTarget = '0;
        bus.fetchReady = 1'b1;
        sbus.stallReq = '0;
        sbus.redirectValid = 1'b1;
        sbus.redirectTarget = 8'hFE;
        sbus.fetchReady = 1'b1;
        tick;
        tick;
        #1;
        chk("reset pc", bus.pc, 32'h0);
        chk("reset fetchValid", bus.fetchValid, 1'b0);
        chk("reset fetchCount", bus.fetchCount, 16'h0);
        chk("reset decodeValid", bus.decodeValid, 1'b0);
        chk("reset redirectTaken", bus.redirectTaken, 1'b0);
        resetN = 1'b1;
        #1 chk("boot fetchValid", bus.fetchValid, 1'b0);
        tick; // E1
        sbus.redirectValid = 1'b0;
        #1;
        chk("E1 fetchValid", bus.fetchValid, 1'b1);
        chk("E1 pc", bus.pc, 32'h0);
        chk("small boot redirect pc", sbus.pc, 8'hFC);
        chk("small redirectTaken", sbus.redirectTaken, 1'b1);
        chk("small bubble fetchValid", sbus.fetchValid, 1'b0);
        tick; // E2
        tick; // E3
        #1;
        chk("small wrap pc", sbus.pc, 8'h00);
        chk("small wrap count", sbus.fetchCount, 2'd1);
        tick; // E4
        #1;
        chk("seq pc", bus.pc, 32'hC);
        chk("seq count", bus.fetchCount, 16'd3);
        chk("seq decodeValid", bus.decodeValid, 1'b1);
        tick; // E5
        bus.stallReq = 7'b0001000;
        #1;
        chk("stall fetchValid", bus.fetchValid, 1'b0);
        chk("stall available", bus.available, 1'b0);
        chk("stall pc", bus.pc, 32'h10);
        tick; // E6
        #1;
        chk("stall decodeValid", bus.decodeValid, 1'b0);
        chk("stall pc hold", bus.pc, 32'h10);
        tick; // E7
        #1;
        chk("small count after 5 fires", sbus.fetchCount, 2'd1);
        chk("small pc after 5 fires", sbus.pc, 8'h10);
        sbus.fetchReady = 1'b0;
        tick; // E8
        bus.stallReq = '0;
        #1;
        chk("resume fetchValid", bus.fetchValid, 1'b1);
        chk("resume pc", bus.pc, 32'h10);
        tick; // E9
        #1;
        chk("resume next pc", bus.pc, 32'h14);
        chk("resume count", bus.fetchCount, 16'd5);
        tick;
        tick;
        tick; // E12
        #1 chk("pre-redirect pc", bus.pc, 32'h20);
        bus.redirectValid = 1'b1;
        bus.redirectTarget = 32'h103;
        tick; // E13
        bus.redirectValid = 1'b0;
        #1;
        chk("redirect pc", bus.pc, 32'h100);
        chk("squash decodeValid", bus.decodeValid, 1'b0);
        chk("redirectTaken pulse", bus.redirectTaken, 1'b1);
        chk("bubble fetchValid", bus.fetchValid, 1'b0);
        chk("squashed fire counted", bus.fetchCount, 16'd9);
        tick; // E14
        #1;
        chk("post-bubble fetchValid", bus.fetchValid, 1'b1);
        chk("redirectTaken drop", bus.redirectTaken, 1'b0);
        chk("post-bubble pc", bus.pc, 32'h100);
        tick; // E15
        #1;
        chk("fire at target pc", bus.pc, 32'h104);
        chk("fire at target count", bus.fetchCount, 16'd10);
        bus.redirectValid = 1'b1;
        bus.redirectTarget = 32'h80;
        tick; // E16
        bus.redirectTarget = 32'h40;
        #1;
        chk("first b2b pc", bus.pc, 32'h80);
        chk("first b2b fetchValid", bus.fetchValid, 1'b0);
        chk("first b2b redirectTaken", bus.redirectTaken, 1'b1);
        tick; // E17
        bus.redirectValid = 1'b0;
        #1;
        chk("second b2b pc", bus.pc, 32'h40);
        chk("second b2b fetchValid", bus.fetchValid, 1'b0);
        chk("second b2b redirectTaken", bus.redirectTaken, 1'b1);
        tick; // E18
        #1 chk("after b2b fetchValid", bus.fetchValid, 1'b1);
        bus.redirectValid = 1'b1;
        bus.redirectTarget = 32'h200;
        tick; // E19: now in BUBBLE
        bus.redirectValid = 1'b0;
        #1 resetN = 1'b0;
        bus.stallReq = 7'h01;
        #1;
        chk("mid reset pc", bus.pc, 32'h0);
        chk("mid reset count", bus.fetchCount, 16'h0);
        chk("mid reset fetchValid", bus.fetchValid, 1'b0);
        chk("mid reset redirectTaken", bus.redirectTaken, 1'b0);
        chk("mid reset available", bus.available, 1'b0);
        tick;
        bus.stallReq = '0;
        #1 chk("reset available follows", bus.available, 1'b1);
        tick;
        resetN = 1'b1;
        #1 chk("release decodeValid", bus.decodeValid, 1'b0);
        tick; // R1
        #1;
        chk("R1 fetchValid", bus.fetchValid, 1'b1);
        chk("R1 pc", bus.pc, 32'h0);
        chk("R1 decodeValid", bus.decodeValid, 1'b0);
        tick; // R2
        #1;
        chk("R2 pc", bus.pc, 32'h4);
        chk("R2 decodeValid", bus.decodeValid, 1'b1);
        bus.fetchReady = 1'b0;
        tick; // R3
        #1;
        chk("not ready pc hold", bus.pc, 32'h4);
        chk("not ready decodeValid", bus.decodeValid, 1'b0);
        for (int i = 0; i < 12; i++) begin
            bus.stallReq = (i % 4 == 1) ? 7'h40 : 7'h00;
            bus.fetchReady = (i % 3 != 2);
            bus.redirectValid = (i == 5 || i == 6);
            bus.redirectTarget = 32'h1000 + 32'(i) * 32'h11;
            tick;
        end
        bus.redirectValid = 1'b0;
        tick;
        tick;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter XLEN, default 32, width of pc and redirect target.
REQ-002 Parameter RESET_VECTOR, default 0, first fetch address after reset.
REQ-003 Parameter INC, default 4, byte increment per fetch; power of two, at least 1.
REQ-004 Parameter NUM_STALL, default 7, number of independent stall request lines.
REQ-005 Parameter CNT_W, default 16, width of fetchCount.
REQ-006 clock  input  1  sole clock; all state updates on rising edge.
REQ-007 resetN  input  1  asynchronous, active-low reset.
REQ-008 stallReq  input  NUM_STALL  any bit high = hold fetch (unit busy/full).
REQ-009 redirectValid  input  1  one-cycle request to load a new pc.
REQ-010 redirectTarget  input  XLEN  new pc, sampled with redirectValid.
REQ-011 fetchReady  input  1  fetch stage accepts the presented pc.
REQ-012 pc  output  XLEN  address presented for fetch.
REQ-013 fetchValid  output  1  pc is valid for fetch this cycle.
REQ-014 available  output  1  combinational NOR of stallReq.
REQ-015 decodeValid  output  1  one-cycle pulse: the previous cycle's fetch is to be decoded.
REQ-016 redirectTaken  output  1  one-cycle pulse: a redirect was applied on the previous edge.
REQ-017 fetchCount  output  CNT_W  number of completed fetches since reset, modulo 2^CNT_W.

Function
REQ-018 States: BOOT, RUN, BUBBLE; a registered state variable holds the current state.
REQ-019 BOOT -> RUN unconditionally on the first edge after reset release; fetchValid=0 in BOOT.
REQ-020 fetchValid = (state==RUN) & available; a stall withdraws fetchValid in the same cycle, and pc holds.
REQ-021 Fire condition = fetchValid & fetchReady; on a fire without redirect, pc <= pc + INC, truncated to XLEN bits (wrap to 0 permitted).
REQ-022 No fire and no redirect: pc, fetchCount and state hold.
REQ-023 fetchCount increments by 1 on every fire, including a fire in the same cycle as a redirect; it wraps to 0 at overflow.
REQ-024 decodeValid is 1 on the cycle after a fire, unless that fire coincided with a redirect (squash); otherwise 0.
REQ-025 redirectValid high at an edge (any state except reset): pc <= redirectTarget with the low log2(INC) bits forced to 0, state <= BUBBLE, redirectTaken=1 next cycle.
REQ-026 Redirect has priority over increment; a redirect in BOOT is accepted and replaces RESET_VECTOR.
REQ-027 BUBBLE: fetchValid=0 for exactly one cycle, then -> RUN regardless of stallReq. A further redirect in BUBBLE reloads pc and stays in BUBBLE one more cycle.
REQ-028 Back-to-back redirects: the last one sampled wins; redirectTaken pulses for each.
REQ-029 All outputs except available and fetchValid are registered.

Reset
REQ-030 resetN low immediately forces: pc=RESET_VECTOR, state=BOOT, fetchValid=0, decodeValid=0, redirectTaken=0, fetchCount=0. available continues to follow stallReq.
REQ-031 Reset asserted mid-fetch or mid-BUBBLE aborts the operation with no decodeValid pulse afterwards; the first fetch after release is at RESET_VECTOR, two edges after release.

Verification
REQ-032 Reset release, stallReq=0, fetchReady=1 -> fetchValid rises on edge 1; pc sequence 0,4,8,12; decodeValid high from the cycle after the first fire; fetchCount=3 after 3 fires.
REQ-033 In RUN at pc=0x10, stallReq[3]=1 for 3 cycles -> fetchValid=0 and available=0 for those cycles; pc holds at 0x10; no decodeValid pulses; resumes at 0x10 then 0x14.
REQ-034 Fire at pc=0x20 with redirectValid=1 and target=0x103 -> pc=0x100; decodeValid=0 next cycle; redirectTaken=1 for 1 cycle; one BUBBLE cycle; next fire at 0x100; fetchCount counts the squashed fire.
REQ-035 XLEN=8, INC=4, pc=0xFC, fire -> pc=0x00; CNT_W=2 and 5 fires -> fetchCount=1.
REQ-036 Redirect to 0x40 in BUBBLE right after a redirect to 0x80 -> pc=0x40; two consecutive fetchValid=0 cycles; two redirectTaken pulses.
REQ-037 resetN low during BUBBLE, then released -> all outputs at reset values immediately; no decodeValid; first fetch at RESET_VECTOR.
